// File: rtl/core_pkg.sv
// Shared core definitions: ALU operation codes, RV32I opcode/funct constants,
// the decode-stage output record and immediate-extraction helpers.
// Imported by id_stage, regfile and the ALU so that all of them agree on
// the alu_ctrl_t encoding.
package core_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned NumRegs = 32;

    // 3'b100, 3'b110 and 3'b111 are reserved and never produced.
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Contents of the decode -> execute pipeline register.
    typedef struct packed {
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] branch_off;
        alu_ctrl_t       alu_ctrl;
        logic [4:0]      rd_addr;
        logic            reg_we;
        logic            mem_re;
        logic            mem_we;
        logic            branch;
        logic            illegal;
    } id_out_t;

    function automatic logic [XLEN-1:0] imm_i(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:20]};
    endfunction

    function automatic logic [XLEN-1:0] imm_s(input logic [31:0] instr);
        return {{20{instr[31]}}, instr[31:25], instr[11:7]};
    endfunction

    function automatic logic [XLEN-1:0] imm_b(input logic [31:0] instr);
        return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/regfile.sv
// 32 x 32 integer register file.
//   clk_i, rst_ni          clock, asynchronous active-low reset (clears all entries)
//   raddr_a_i/rdata_a_o    asynchronous read port A
//   raddr_b_i/rdata_b_o    asynchronous read port B
//   we_i/waddr_i/wdata_i   synchronous write port
// x0 always reads 0 and ignores writes. A read that hits the register being
// written in the same cycle returns the write data (write-through bypass).
module regfile
    import core_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [4:0]      raddr_a_i,
    output logic [XLEN-1:0] rdata_a_o,
    input  logic [4:0]      raddr_b_i,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [4:0]      waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [NumRegs];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i != 5'd0) begin
            rdata_a_o = (we_i && (waddr_i == raddr_a_i)) ? wdata_i : mem_q[raddr_a_i];
        end
    end

    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i != 5'd0) begin
            rdata_b_o = (we_i && (waddr_i == raddr_b_i)) ? wdata_i : mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage.
//   in_valid_i/in_ready_o/instr_i   instruction handshake (in_ready_o is combinational)
//   out_valid_o/out_ready_i         output pipeline-register handshake
//   rs1_val_o, rs2_val_o            ALU operands (rs2_val_o is register or immediate)
//   store_data_o                    rs2 register value for sw, else 0
//   alu_ctrl_o                      alu_ctrl_t operation code
//   rd_addr_o, reg_we_o             destination register and write enable
//   mem_re_o, mem_we_o, branch_o    lw / sw / beq flags
//   branch_off_o                    sign-extended B-immediate for beq, else 0
//   illegal_o                       unsupported encoding
//   wb_en_i/wb_addr_i/wb_data_i     writeback port into the register file
// A pending-register scoreboard stalls issue on RAW/WAW hazards until the
// matching writeback arrives.
module id_stage
    import core_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     instr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] rs1_val_o,
    output logic [XLEN-1:0] rs2_val_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [2:0]      alu_ctrl_o,
    output logic [4:0]      rd_addr_o,
    output logic            reg_we_o,
    output logic            mem_re_o,
    output logic            mem_we_o,
    output logic            branch_o,
    output logic [XLEN-1:0] branch_off_o,
    output logic            illegal_o,
    input  logic            wb_en_i,
    input  logic [4:0]      wb_addr_i,
    input  logic [XLEN-1:0] wb_data_i
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_field;

    assign opcode   = instr_i[6:0];
    assign rd_field = instr_i[11:7];
    assign funct3   = instr_i[14:12];
    assign rs1_addr = instr_i[19:15];
    assign rs2_addr = instr_i[24:20];
    assign funct7   = instr_i[31:25];

    logic [XLEN-1:0] rf_rdata_a;
    logic [XLEN-1:0] rf_rdata_b;

    regfile u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .raddr_a_i (rs1_addr),
        .rdata_a_o (rf_rdata_a),
        .raddr_b_i (rs2_addr),
        .rdata_b_o (rf_rdata_b),
        .we_i      (wb_en_i),
        .waddr_i   (wb_addr_i),
        .wdata_i   (wb_data_i)
    );

    // ---------------- Decode ----------------
    logic            dec_illegal;
    alu_ctrl_t       dec_alu;
    logic            dec_use_rs2;
    logic            dec_writes_rd;
    logic            dec_imm_op;
    logic [XLEN-1:0] dec_imm;
    logic            dec_mem_re;
    logic            dec_mem_we;
    logic            dec_branch;

    always_comb begin
        dec_illegal   = 1'b0;
        dec_alu       = ALU_ADD;
        dec_use_rs2   = 1'b0;
        dec_writes_rd = 1'b0;
        dec_imm_op    = 1'b0;
        dec_imm       = '0;
        dec_mem_re    = 1'b0;
        dec_mem_we    = 1'b0;
        dec_branch    = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_use_rs2   = 1'b1;
                dec_writes_rd = 1'b1;
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADD_SUB: dec_alu = ALU_ADD;
                        F3_AND:     dec_alu = ALU_AND;
                        F3_OR:      dec_alu = ALU_OR;
                        F3_SLT:     dec_alu = ALU_SLT;
                        default:    dec_illegal = 1'b1;
                    endcase
                end else if ((funct7 == F7_SUB) && (funct3 == F3_ADD_SUB)) begin
                    dec_alu = ALU_SUB;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_writes_rd = 1'b1;
                dec_imm_op    = 1'b1;
                dec_imm       = imm_i(instr_i);
                case (funct3)
                    F3_ADD_SUB: dec_alu = ALU_ADD;
                    F3_AND:     dec_alu = ALU_AND;
                    F3_OR:      dec_alu = ALU_OR;
                    F3_SLT:     dec_alu = ALU_SLT;
                    default:    dec_illegal = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                dec_writes_rd = 1'b1;
                dec_imm_op    = 1'b1;
                dec_imm       = imm_i(instr_i);
                dec_mem_re    = 1'b1;
                dec_illegal   = (funct3 != F3_LW);
            end
            OPC_STORE: begin
                // rs2 is still read: it supplies the store data.
                dec_use_rs2 = 1'b1;
                dec_imm_op  = 1'b1;
                dec_imm     = imm_s(instr_i);
                dec_mem_we  = 1'b1;
                dec_illegal = (funct3 != F3_SW);
            end
            OPC_BRANCH: begin
                dec_use_rs2 = 1'b1;
                dec_alu     = ALU_SUB;
                dec_branch  = 1'b1;
                dec_illegal = (funct3 != F3_BEQ);
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Illegal encodings produce an all-zero record apart from the flag and
    // use no registers, so they can never stall.
    id_out_t dec;
    logic    use_rs1;
    logic    use_rs2;

    always_comb begin
        dec     = '0;
        use_rs1 = !dec_illegal;
        use_rs2 = dec_use_rs2 && !dec_illegal;
        if (!dec_illegal) begin
            dec.rs1_val    = rf_rdata_a;
            dec.rs2_val    = dec_imm_op ? dec_imm : rf_rdata_b;
            dec.store_data = dec_mem_we ? rf_rdata_b : '0;
            dec.branch_off = dec_branch ? imm_b(instr_i) : '0;
            dec.alu_ctrl   = dec_alu;
            dec.reg_we     = dec_writes_rd && (rd_field != 5'd0);
            dec.rd_addr    = dec.reg_we ? rd_field : 5'd0;
            dec.mem_re     = dec_mem_re;
            dec.mem_we     = dec_mem_we;
            dec.branch     = dec_branch;
        end
        dec.illegal = dec_illegal;
    end

    // ---------------- Scoreboard / handshake ----------------
    logic [NumRegs-1:0] pending_q;
    logic [NumRegs-1:0] pending_d;
    logic [NumRegs-1:0] wb_clr;
    logic [NumRegs-1:0] pending_eff;
    logic               out_valid_q;
    logic               out_valid_d;
    id_out_t            out_q;
    id_out_t            out_d;
    logic               stall;
    logic               accept;

    always_comb begin
        wb_clr = wb_en_i ? (32'd1 << wb_addr_i) : '0;
        // A register being written back this cycle no longer blocks issue.
        pending_eff = pending_q & ~wb_clr;
        stall = in_valid_i && ((use_rs1 && pending_eff[rs1_addr])
                            || (use_rs2 && pending_eff[rs2_addr])
                            || (dec.reg_we && pending_eff[rd_field]));
    end

    assign in_ready_o = !stall && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;

    always_comb begin
        pending_d = pending_eff;
        // Applied after the clear so a same-cycle set on the same register wins.
        if (accept && dec.reg_we) begin
            pending_d[rd_field] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_d       = dec;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign rs1_val_o    = out_q.rs1_val;
    assign rs2_val_o    = out_q.rs2_val;
    assign store_data_o = out_q.store_data;
    assign alu_ctrl_o   = out_q.alu_ctrl;
    assign rd_addr_o    = out_q.rd_addr;
    assign reg_we_o     = out_q.reg_we;
    assign mem_re_o     = out_q.mem_re;
    assign mem_we_o     = out_q.mem_we;
    assign branch_o     = out_q.branch;
    assign branch_off_o = out_q.branch_off;
    assign illegal_o    = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Self-checking bench for id_stage: directed scenarios followed by random
// traffic, all compared against an instruction-level reference model.
module tb_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] instr_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] rs1_val_o;
    logic [31:0] rs2_val_o;
    logic [31:0] store_data_o;
    logic [2:0]  alu_ctrl_o;
    logic [4:0]  rd_addr_o;
    logic        reg_we_o;
    logic        mem_re_o;
    logic        mem_we_o;
    logic        branch_o;
    logic [31:0] branch_off_o;
    logic        illegal_o;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;

    id_stage dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .instr_i      (instr_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .rs1_val_o    (rs1_val_o),
        .rs2_val_o    (rs2_val_o),
        .store_data_o (store_data_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .rd_addr_o    (rd_addr_o),
        .reg_we_o     (reg_we_o),
        .mem_re_o     (mem_re_o),
        .mem_we_o     (mem_we_o),
        .branch_o     (branch_o),
        .branch_off_o (branch_off_o),
        .illegal_o    (illegal_o),
        .wb_en_i      (wb_en_i),
        .wb_addr_i    (wb_addr_i),
        .wb_data_i    (wb_data_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- Reference model ----------------
    typedef struct {
        logic [31:0] a, b, sd, off;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic        we, re, me, br, ill;
    } exp_t;

    logic [31:0] m_regs [32];
    logic [31:0] m_pend;
    logic        m_ov;
    exp_t        m_out;
    logic        last_ready;
    logic        m_acc;

    function automatic exp_t zero_exp();
        exp_t e;
        e.a = 0; e.b = 0; e.sd = 0; e.off = 0; e.alu = 0; e.rd = 0;
        e.we = 0; e.re = 0; e.me = 0; e.br = 0; e.ill = 0;
        return e;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 0;
        m_pend = 0;
        m_ov   = 0;
        m_out  = zero_exp();
    endtask

    // Architectural read as seen in the accept cycle, including writeback forwarding.
    function automatic logic [31:0] m_read(input logic [4:0] r);
        if (r == 0) return 0;
        if (wb_en_i && wb_addr_i == r) return wb_data_i;
        return m_regs[r];
    endfunction

    function automatic exp_t m_decode(input logic [31:0] ins, output bit u1, output bit u2);
        exp_t e = zero_exp();
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        logic [4:0] rd = ins[11:7];
        logic [31:0] ii = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] si = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        logic [31:0] bi = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        int op_id = -1;  // 0 add, 1 sub, 2 and, 3 or, 4 slt
        bit is_r = 0, is_i = 0, is_lw = 0, is_sw = 0, is_beq = 0;
        if (op == 7'h33 && f7 == 0) begin
            is_r = 1;
            op_id = (f3 == 0) ? 0 : (f3 == 7) ? 2 : (f3 == 6) ? 3 : (f3 == 2) ? 4 : -1;
        end else if (op == 7'h33 && f7 == 7'h20 && f3 == 0) begin
            is_r = 1; op_id = 1;
        end else if (op == 7'h13) begin
            is_i = 1;
            op_id = (f3 == 0) ? 0 : (f3 == 7) ? 2 : (f3 == 6) ? 3 : (f3 == 2) ? 4 : -1;
        end else if (op == 7'h03 && f3 == 2) begin
            is_lw = 1; op_id = 0;
        end else if (op == 7'h23 && f3 == 2) begin
            is_sw = 1; op_id = 0;
        end else if (op == 7'h63 && f3 == 0) begin
            is_beq = 1; op_id = 1;
        end
        u1 = 0; u2 = 0;
        if (op_id < 0) begin
            e.ill = 1;
            return e;
        end
        u1 = 1;
        u2 = is_r || is_sw || is_beq;
        case (op_id)
            0: e.alu = 3'd0;
            1: e.alu = 3'd1;
            2: e.alu = 3'd2;
            3: e.alu = 3'd3;
            default: e.alu = 3'd5;
        endcase
        e.a   = m_read(ins[19:15]);
        e.b   = (is_i || is_lw) ? ii : is_sw ? si : m_read(ins[24:20]);
        e.sd  = is_sw ? m_read(ins[24:20]) : 0;
        e.off = is_beq ? bi : 0;
        e.we  = (is_r || is_i || is_lw) && rd != 0;
        e.rd  = e.we ? rd : 0;
        e.re  = is_lw;
        e.me  = is_sw;
        e.br  = is_beq;
        return e;
    endfunction

    task automatic chk_outputs(input string tag);
        chk({tag, ".out_valid"}, {31'd0, out_valid_o}, {31'd0, m_ov});
        chk({tag, ".rs1_val"}, rs1_val_o, m_out.a);
        chk({tag, ".rs2_val"}, rs2_val_o, m_out.b);
        chk({tag, ".store_data"}, store_data_o, m_out.sd);
        chk({tag, ".branch_off"}, branch_off_o, m_out.off);
        chk({tag, ".alu_ctrl"}, {29'd0, alu_ctrl_o}, {29'd0, m_out.alu});
        chk({tag, ".rd_addr"}, {27'd0, rd_addr_o}, {27'd0, m_out.rd});
        chk({tag, ".flags"}, {27'd0, reg_we_o, mem_re_o, mem_we_o, branch_o, illegal_o},
            {27'd0, m_out.we, m_out.re, m_out.me, m_out.br, m_out.ill});
    endtask

    // One clock: inputs are already driven. Checks in_ready before the edge and
    // every output after it.
    task automatic cycle(input string tag);
        exp_t e;
        bit u1, u2, stall, ready;
        logic [31:0] pe;
        #1;
        e  = m_decode(instr_i, u1, u2);
        pe = m_pend;
        if (wb_en_i) pe[wb_addr_i] = 1'b0;
        stall = in_valid_i && ((u1 && pe[instr_i[19:15]]) || (u2 && pe[instr_i[24:20]])
                               || (e.we && pe[e.rd]));
        ready = !stall && (!m_ov || out_ready_i);
        last_ready = in_ready_o;
        chk({tag, ".in_ready"}, {31'd0, in_ready_o}, {31'd0, ready});
        @(posedge clk_i);
        m_acc = in_valid_i && ready;
        if (m_acc) begin
            m_out = e;
            m_ov  = 1;
        end else if (out_ready_i) begin
            m_ov = 0;
        end
        if (wb_en_i && wb_addr_i != 0) begin
            m_regs[wb_addr_i] = wb_data_i;
            m_pend[wb_addr_i] = 1'b0;
        end
        if (m_acc && e.we) m_pend[e.rd] = 1'b1;
        #1;
        chk_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        in_valid_i  = v;
        instr_i     = ins;
        out_ready_i = ordy;
        wb_en_i     = we;
        wb_addr_i   = wa;
        wb_data_i   = wd;
    endtask

    // ---------------- Encoders ----------------
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [2:0]  f3tab [4] = '{3'd0, 3'd7, 3'd6, 3'd2};
        logic [31:0] r   = $urandom;
        logic [4:0]  d   = 5'($urandom_range(0, 7));
        logic [4:0]  s1  = 5'($urandom_range(0, 7));
        logic [4:0]  s2  = 5'($urandom_range(0, 7));
        logic [2:0]  f3  = f3tab[$urandom_range(0, 3)];
        int          k   = $urandom_range(0, 9);
        case (k)
            0, 1:    return enc_r(7'h00, s2, s1, f3, d);
            2, 3:    return enc_i(r[11:0], s1, f3, d, 7'b0010011);
            4:       return enc_i(r[11:0], s1, 3'b010, d, 7'b0000011);
            5:       return enc_s(r[11:0], s2, s1);
            6:       return enc_b(r[12:0], s2, s1);
            7:       return enc_r(7'h20, s2, s1, 3'd0, d);
            8:       return r;
            default: return enc_r(7'h01, s2, s1, 3'd0, d);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running, required done");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] cur_ins;
        logic        cur_v;
        rst_ni = 1'b0;
        drive(0, 0, 1, 0, 0, 0);
        m_reset();
        last_ready = 0;
        m_acc = 0;
        #3;
        chk("reset.out_valid", {31'd0, out_valid_o}, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready_o}, 32'd1);
        chk_outputs("reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Seed x1=20, x2=30 via writeback, then add x3,x1,x2.
        drive(0, 0, 1, 1, 5'd1, 32'd20);  cycle("wb_x1");
        drive(0, 0, 1, 1, 5'd2, 32'd30);  cycle("wb_x2");
        drive(1, enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3), 1, 0, 0, 0);
        cycle("add");
        chk("add.out_valid", {31'd0, out_valid_o}, 32'd1);
        chk("add.rs1_val", rs1_val_o, 32'd20);
        chk("add.rs2_val", rs2_val_o, 32'd30);
        chk("add.alu_ctrl", {29'd0, alu_ctrl_o}, 32'd0);
        chk("add.rd_addr", {27'd0, rd_addr_o}, 32'd3);
        chk("add.reg_we", {31'd0, reg_we_o}, 32'd1);

        // addi x5,x0,-4 then slti x6,x5,1 stalls until x5 is written back.
        drive(1, enc_i(12'hFFC, 5'd0, 3'd0, 5'd5, 7'b0010011), 1, 0, 0, 0);
        cycle("addi");
        chk("addi.rs2_val", rs2_val_o, 32'hFFFF_FFFC);
        drive(1, enc_i(12'd1, 5'd5, 3'd2, 5'd6, 7'b0010011), 1, 0, 0, 0);
        cycle("slti_stall0");
        chk("slti_stall0.in_ready", {31'd0, last_ready}, 32'd0);
        cycle("slti_stall1");
        chk("slti_stall1.out_valid", {31'd0, out_valid_o}, 32'd0);
        drive(1, enc_i(12'd1, 5'd5, 3'd2, 5'd6, 7'b0010011), 1, 1, 5'd5, 32'hFFFF_FFFC);
        cycle("slti_bypass");
        chk("slti_bypass.in_ready", {31'd0, last_ready}, 32'd1);
        chk("slti_bypass.rs1_val", rs1_val_o, 32'hFFFF_FFFC);
        chk("slti_bypass.alu_ctrl", {29'd0, alu_ctrl_o}, 32'd5);
        chk("slti_bypass.rs2_val", rs2_val_o, 32'd1);

        // sw x2,8(x1)
        drive(1, enc_s(12'd8, 5'd2, 5'd1), 1, 0, 0, 0);
        cycle("sw");
        chk("sw.mem_we", {31'd0, mem_we_o}, 32'd1);
        chk("sw.reg_we", {31'd0, reg_we_o}, 32'd0);
        chk("sw.rs2_val", rs2_val_o, 32'd8);
        chk("sw.store_data", store_data_o, 32'd30);

        // beq x1,x2,-16
        drive(1, enc_b(13'h1FF0, 5'd2, 5'd1), 1, 0, 0, 0);
        cycle("beq");
        chk("beq.alu_ctrl", {29'd0, alu_ctrl_o}, 32'd1);
        chk("beq.branch", {31'd0, branch_o}, 32'd1);
        chk("beq.branch_off", branch_off_o, 32'hFFFF_FFF0);

        // Back-pressure: three held cycles, then back-to-back issue.
        drive(1, enc_i(12'd1, 5'd1, 3'd0, 5'd8, 7'b0010011), 1, 0, 0, 0);
        cycle("hold_pre");
        for (int i = 0; i < 3; i++) begin
            drive(1, enc_i(12'd2, 5'd1, 3'd0, 5'd9, 7'b0010011), 0, 0, 0, 0);
            cycle("hold");
            chk("hold.in_ready", {31'd0, last_ready}, 32'd0);
            chk("hold.rs2_val", rs2_val_o, 32'd1);
        end
        drive(1, enc_i(12'd2, 5'd1, 3'd0, 5'd9, 7'b0010011), 1, 0, 0, 0);
        cycle("release");
        chk("release.rs2_val", rs2_val_o, 32'd2);
        drive(1, enc_i(12'd3, 5'd1, 3'd0, 5'd10, 7'b0010011), 1, 0, 0, 0);
        cycle("b2b");
        chk("b2b.out_valid", {31'd0, out_valid_o}, 32'd1);
        chk("b2b.rs2_val", rs2_val_o, 32'd3);

        // Illegal word never stalls.
        drive(1, 32'hFFFF_FFFF, 1, 0, 0, 0);
        cycle("illegal");
        chk("illegal.in_ready", {31'd0, last_ready}, 32'd1);
        chk("illegal.flag", {31'd0, illegal_o}, 32'd1);
        chk("illegal.reg_we", {31'd0, reg_we_o}, 32'd0);

        // add x11,x3,x0 stalls on pending x3; reset mid-stall clears everything.
        drive(1, enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd11), 1, 0, 0, 0);
        cycle("pre_reset_stall");
        chk("pre_reset_stall.in_ready", {31'd0, last_ready}, 32'd0);
        rst_ni = 1'b0;
        m_reset();
        #2;
        chk("mid_reset.in_ready", {31'd0, in_ready_o}, 32'd1);
        chk_outputs("mid_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        cycle("post_reset");
        chk("post_reset.in_ready", {31'd0, last_ready}, 32'd1);
        chk("post_reset.rs1_val", rs1_val_o, 32'd0);

        // Random traffic against the model.
        cur_ins = rand_instr();
        cur_v   = 1'b1;
        for (int n = 0; n < 600; n++) begin
            logic       we = 0;
            logic [4:0] wa = 0;
            if ($urandom_range(0, 1) == 1) begin
                int start = $urandom_range(0, 31);
                we = 1;
                wa = 5'($urandom_range(0, 7));
                for (int j = 0; j < 32; j++) begin
                    if (m_pend[(start + j) % 32]) wa = 5'((start + j) % 32);
                end
            end
            drive(cur_v, cur_ins, $urandom_range(0, 3) != 0, we, wa, $urandom);
            cycle("rand");
            if (m_acc || !cur_v) begin
                cur_ins = rand_instr();
                cur_v   = $urandom_range(0, 3) != 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the core, directly upstream of the ALU. Accepts one RV32I instruction per handshake, decodes it, reads operands from an internal 32x32 register file, and registers operands, ALU control, and side-band control into a single output pipeline register consumed by the ALU/execute stage. A register-pending scoreboard stalls issue on RAW/WAW hazards until writeback clears them. Writeback from the end of the pipe enters through a dedicated write port.

## Interface
- No parameters. Widths are fixed: XLEN 32, 32 registers.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instr/pc valid
- in_ready  out  1  stage accepts this cycle (combinational)
- instr  in  32  instruction word
- out_valid  out  1  output register holds a decoded instruction
- out_ready  in  1  downstream accepts this cycle
- rs1_val  out  32  ALU operand a
- rs2_val  out  32  ALU operand b (register or sign-extended immediate)
- store_data  out  32  rs2 register value (stores only, else 0)
- alu_ctrl  out  3  ALU operation code
- rd_addr  out  5  destination register
- reg_we  out  1  instruction writes rd
- mem_re / mem_we  out  1 each  load / store
- branch  out  1  beq; downstream uses ALU z
- branch_off  out  32  sign-extended B-immediate
- illegal  out  1  unsupported encoding
- wb_en  in  1  writeback strobe
- wb_addr  in  5  writeback register
- wb_data  in  32  writeback value

## Operation
- Supported: R-type add/sub/and/or/slt (opcode 0110011), I-type addi/andi/ori/slti (0010011), lw (0000011), sw (0100011), beq (1100011, funct3 000).
- alu_ctrl: add 000, sub 001, and 010, or 011, slt 101; 100/110/111 never driven.
- Mapping: add/addi/lw/sw -> 000; sub/beq -> 001; and/andi -> 010; or/ori -> 011; slt/slti -> 101.
- rs2_val = register rs2 for R-type/beq; I-immediate for I-type/lw; S-immediate for sw.
- reg_we = 1 for R-type, I-type, and lw, but 0 when rd = 0.
- Illegal encoding: illegal = 1, alu_ctrl 000, operands 0, reg_we/mem_re/mem_we/branch = 0. Still passes the handshake and sets no pending bit.
- Register file: x0 reads 0 and ignores writes. A write with wb_en is committed at the clock edge.
- Read bypass: if wb_en and wb_addr == a source register (non-zero) in the accept cycle, wb_data is used.
- Scoreboard: a 32-bit pending vector.
  - Accepting an instruction with reg_we sets pending[rd].
  - wb_en clears pending[wb_addr].
  - If set and clear hit the same register in the same cycle, set wins.
  - pending[0] is constantly 0.
- Stall condition: in_valid and any of:
  - rs1 is pending and used by the instruction;
  - rs2 is pending and used (R-type, sw, beq);
  - rd is pending and reg_we is set.
  - A pending bit being cleared by wb_en in the same cycle counts as not pending.
- in_ready = !stall && (!out_valid || out_ready).
- Illegal encodings never stall.

## Timing
- Reset, asynchronous: out_valid 0, every output data/control register 0, pending vector 0, all 32 registers 0.
- in_ready is 1 during reset when not stalled.
- Latency: an instruction accepted at edge N appears with out_valid = 1 after edge N. One-cycle decode.
- Throughput: 1 instruction per cycle with no hazards and out_ready held high.
- While out_valid && !out_ready, all outputs hold stable and in_ready = 0.
- Accept and drain in the same cycle: the output register is overwritten and out_valid stays 1, with no bubble.
- Without accept: out_valid falls after an edge where out_ready = 1.
- Reset mid-stall or mid-transfer drops the instruction and clears the scoreboard. No output glitch after deassertion.

## Structure
- Package core_pkg:
  - alu_ctrl_t enum: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - opcode constants;
  - funct3/funct7 constants;
  - immediate-extraction functions.
- The ALU imports the same alu_ctrl_t.
- One sub-module: regfile. It has 2 async read ports, 1 sync write port, async reset, and x0 hardwired. Bypass is inside regfile.
- Decode, scoreboard, and the output register live in id_stage.

## Test plan
- Reset, then add x3,x1,x2 after wb x1=20, x2=30 -> next cycle out_valid = 1, rs1_val 20, rs2_val 30, alu_ctrl 000, rd_addr 3, reg_we 1.
- addi x5,x0,-4 then slti x6,x5,1, with no writeback -> first instruction issues. The second has in_ready = 0 until wb_en x5 = 0xFFFFFFFC, then issues the same cycle with rs1_val 0xFFFFFFFC (bypass), alu_ctrl 101, rs2_val 1.
- sw x2,8(x1) -> mem_we 1, reg_we 0, rs2_val 8, store_data equals x2, alu_ctrl 000. No pending bit is set.
- beq x1,x2,-16 -> alu_ctrl 001, branch 1, branch_off 0xFFFFFFF0, reg_we 0.
- Hold out_ready = 0 for 3 cycles with in_valid = 1 -> outputs stable, in_ready = 0. Release -> back-to-back issue without a bubble.
- Illegal word 0xFFFFFFFF -> illegal 1, reg_we 0, no stall. Assert rst_n = 0 mid-stall -> all outputs 0 immediately, and pending clears.
